// File: rtl/spi_copy_pkg.sv
// Shared types and default constants for the SPI flash read sequencer.
package spi_copy_pkg;

  localparam logic [31:0] CHUNK_BYTES_DEF    = 32'h0001_0000;
  localparam logic [31:0] DIE_BYTES_DEF      = 32'h0200_0000;
  localparam int          SETTLE_CYCLES_DEF  = 16;
  localparam int          TIMEOUT_CYCLES_DEF = 1048576;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_ISSUE,
    ST_WAIT,
    ST_PAUSE,
    ST_NEXT,
    ST_RELEASE,
    ST_DONE,
    ST_ERR
  } state_e;

  // One reader segment as seen on the rd_* interface.
  typedef struct packed {
    logic [31:0] start_addr;
    logic [31:0] end_addr;
    logic        switch_die;
  } seg_t;

endpackage

// File: rtl/spi_seg_calc.sv
// Combinational segment-bounds calculator: clips a segment at the chunk
// size, the die boundary and the image end, and flags die changes.
module spi_seg_calc
  import spi_copy_pkg::*;
#(
  parameter logic [31:0] CHUNK_BYTES = CHUNK_BYTES_DEF,
  parameter logic [31:0] DIE_BYTES   = DIE_BYTES_DEF
) (
  input  logic [31:0] addr,
  input  logic [31:0] img_end,
  input  logic [31:0] prev_die,
  input  logic        first_seg,
  output logic [31:0] seg_end,
  output logic [31:0] die_idx,
  output logic        switch_die
);

  localparam int DIE_SHIFT = $clog2(DIE_BYTES);

  logic [32:0] chunk_end;
  logic [32:0] die_end;
  logic [32:0] lim;

  // 33-bit sums so a segment near 32'hFFFF_FFFF cannot wrap to a small end.
  always_comb begin
    chunk_end  = {1'b0, addr} + {1'b0, CHUNK_BYTES} - 33'd1;
    die_end    = {1'b0, addr & ~(DIE_BYTES - 32'd1)} + {1'b0, DIE_BYTES} - 33'd1;
    lim        = (chunk_end < die_end) ? chunk_end : die_end;
    seg_end    = (lim < {1'b0, img_end}) ? lim[31:0] : img_end;
    die_idx    = addr >> DIE_SHIFT;
    switch_die = first_seg ? (die_idx != 32'd0) : (die_idx != prev_die);
  end

endmodule

// File: rtl/spi_read_sequencer.sv
// Copies a flash image by grabbing the flash bus, handing the reader one
// segment at a time, and releasing the bus when done, aborted or faulted.
module spi_read_sequencer
  import spi_copy_pkg::*;
#(
  parameter logic [31:0] CHUNK_BYTES    = CHUNK_BYTES_DEF,
  parameter logic [31:0] DIE_BYTES      = DIE_BYTES_DEF,
  parameter int          SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        system_clk,
  input  logic        system_reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] img_start_addr,
  input  logic [31:0] img_end_addr,
  output logic        rd_start_flag,
  output logic [31:0] rd_start_addr,
  output logic [31:0] rd_end_addr,
  output logic        rd_switch_die,
  input  logic        rd_finish,
  input  logic        fifo_full,
  input  logic        fifo_empty,
  output logic        mux_sel,
  output logic        oe_ctl,
  output logic        busy_n,
  output logic        completed_n,
  output logic        error,
  output logic [15:0] seg_count
);

  localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] img_end_q, img_end_d;
  logic [31:0] prev_die_q, prev_die_d;
  logic        first_q, first_d;
  logic        aborted_q, aborted_d;
  logic        rd_start_flag_q, rd_start_flag_d;
  logic [31:0] rd_start_addr_q, rd_start_addr_d;
  logic [31:0] rd_end_addr_q, rd_end_addr_d;
  logic        rd_switch_die_q, rd_switch_die_d;
  logic        mux_sel_q, mux_sel_d;
  logic        oe_ctl_q, oe_ctl_d;
  logic        busy_n_q, busy_n_d;
  logic        completed_n_q, completed_n_d;
  logic        error_q, error_d;
  logic [15:0] seg_count_q, seg_count_d;

  logic [31:0] seg_end;
  logic [31:0] seg_die;
  logic        seg_switch;
  logic        go_rel;

  spi_seg_calc #(
    .CHUNK_BYTES(CHUNK_BYTES),
    .DIE_BYTES  (DIE_BYTES)
  ) u_seg_calc (
    .addr      (addr_q),
    .img_end   (img_end_q),
    .prev_die  (prev_die_q),
    .first_seg (first_q),
    .seg_end   (seg_end),
    .die_idx   (seg_die),
    .switch_die(seg_switch)
  );

  // Next-state and output logic; abort wins over every other event while
  // the bus is held, and a release always runs the settle delay.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q + 32'd1;
    addr_d          = addr_q;
    img_end_d       = img_end_q;
    prev_die_d      = prev_die_q;
    first_d         = first_q;
    aborted_d       = aborted_q;
    rd_start_flag_d = 1'b0;
    rd_start_addr_d = rd_start_addr_q;
    rd_end_addr_d   = rd_end_addr_q;
    rd_switch_die_d = rd_switch_die_q;
    mux_sel_d       = mux_sel_q;
    oe_ctl_d        = oe_ctl_q;
    busy_n_d        = busy_n_q;
    completed_n_d   = completed_n_q;
    error_d         = error_q;
    seg_count_d     = seg_count_q;
    go_rel          = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          completed_n_d = 1'b1;
          error_d       = 1'b0;
          seg_count_d   = 16'd0;
          aborted_d     = 1'b0;
          addr_d        = img_start_addr;
          img_end_d     = img_end_addr;
          first_d       = 1'b1;
          cnt_d         = 32'd0;
          if (img_end_addr < img_start_addr) begin
            error_d = 1'b1;
            state_d = ST_ERR;
          end else begin
            mux_sel_d = 1'b1;
            oe_ctl_d  = 1'b1;
            busy_n_d  = 1'b0;
            state_d   = ST_ACQUIRE;
          end
        end
      end
      ST_ACQUIRE: begin
        if (abort) begin
          aborted_d = 1'b1;
          go_rel    = 1'b1;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          aborted_d = 1'b1;
          go_rel    = 1'b1;
        end else begin
          // Registered launch: the flag and bounds appear together next cycle.
          rd_start_flag_d = 1'b1;
          rd_start_addr_d = addr_q;
          rd_end_addr_d   = seg_end;
          rd_switch_die_d = seg_switch;
          prev_die_d      = seg_die;
          first_d         = 1'b0;
          cnt_d           = 32'd0;
          state_d         = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          aborted_d = 1'b1;
          go_rel    = 1'b1;
        end else if (rd_finish) begin
          if (seg_count_q != 16'hFFFF) seg_count_d = seg_count_q + 16'd1;
          state_d = fifo_full ? ST_PAUSE : ST_NEXT;
        end else if (cnt_q == TIMEOUT_LAST) begin
          error_d = 1'b1;
          go_rel  = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (abort) begin
          aborted_d = 1'b1;
          go_rel    = 1'b1;
        end else if (fifo_empty) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (rd_end_addr_q == img_end_q) begin
          go_rel = 1'b1;
        end else begin
          addr_d  = rd_end_addr_q + 32'd1;
          state_d = ST_ISSUE;
        end
      end
      ST_RELEASE: begin
        if (cnt_q == SETTLE_LAST) begin
          busy_n_d = 1'b1;
          if (aborted_q) begin
            state_d = ST_IDLE;
          end else if (error_q) begin
            state_d = ST_ERR;
          end else begin
            completed_n_d = 1'b0;
            state_d       = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus handoff is dropped on entry to RELEASE; an abort also clears status.
    if (go_rel) begin
      mux_sel_d = 1'b0;
      oe_ctl_d  = 1'b0;
      cnt_d     = 32'd0;
      state_d   = ST_RELEASE;
      if (aborted_d) begin
        completed_n_d = 1'b1;
        error_d       = 1'b0;
      end
    end
  end

  // State and output registers; reset frees the bus immediately.
  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= 32'd0;
      addr_q          <= 32'd0;
      img_end_q       <= 32'd0;
      prev_die_q      <= 32'd0;
      first_q         <= 1'b1;
      aborted_q       <= 1'b0;
      rd_start_flag_q <= 1'b0;
      rd_start_addr_q <= 32'd0;
      rd_end_addr_q   <= 32'd0;
      rd_switch_die_q <= 1'b0;
      mux_sel_q       <= 1'b0;
      oe_ctl_q        <= 1'b0;
      busy_n_q        <= 1'b1;
      completed_n_q   <= 1'b1;
      error_q         <= 1'b0;
      seg_count_q     <= 16'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      addr_q          <= addr_d;
      img_end_q       <= img_end_d;
      prev_die_q      <= prev_die_d;
      first_q         <= first_d;
      aborted_q       <= aborted_d;
      rd_start_flag_q <= rd_start_flag_d;
      rd_start_addr_q <= rd_start_addr_d;
      rd_end_addr_q   <= rd_end_addr_d;
      rd_switch_die_q <= rd_switch_die_d;
      mux_sel_q       <= mux_sel_d;
      oe_ctl_q        <= oe_ctl_d;
      busy_n_q        <= busy_n_d;
      completed_n_q   <= completed_n_d;
      error_q         <= error_d;
      seg_count_q     <= seg_count_d;
    end
  end

  assign rd_start_flag = rd_start_flag_q;
  assign rd_start_addr = rd_start_addr_q;
  assign rd_end_addr   = rd_end_addr_q;
  assign rd_switch_die = rd_switch_die_q;
  assign mux_sel       = mux_sel_q;
  assign oe_ctl        = oe_ctl_q;
  assign busy_n        = busy_n_q;
  assign completed_n   = completed_n_q;
  assign error         = error_q;
  assign seg_count     = seg_count_q;

endmodule

// File: tb/tb_spi_read_sequencer.sv
// Scoreboard bench: tests queue expected segments, a monitor pops one per
// rd_start_flag and compares the launched bounds.
module tb_spi_read_sequencer;
  import spi_copy_pkg::*;

  localparam int SETTLE = 16;
  localparam int TMO    = 300;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, rd_finish = 1'b0;
  logic        fifo_full = 1'b0, fifo_empty = 1'b1;
  logic [31:0] img_s = '0, img_e = '0;
  logic        rd_start_flag, rd_switch_die, mux_sel, oe_ctl, busy_n, completed_n, error;
  logic [31:0] rd_start_addr, rd_end_addr;
  logic [15:0] seg_count;

  int   errors = 0, checks = 0, cyc = 0, flag_cnt = 0, last_flag_cyc = 0, nf = 0;
  logic prev_flag = 1'b0, mux_seen = 1'b0;
  seg_t exp_q[$];

  spi_read_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .system_clk    (clk),
    .system_reset_n(rst_n),
    .start         (start),
    .abort         (abort),
    .img_start_addr(img_s),
    .img_end_addr  (img_e),
    .rd_start_flag (rd_start_flag),
    .rd_start_addr (rd_start_addr),
    .rd_end_addr   (rd_end_addr),
    .rd_switch_die (rd_switch_die),
    .rd_finish     (rd_finish),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .mux_sel       (mux_sel),
    .oe_ctl        (oe_ctl),
    .busy_n        (busy_n),
    .completed_n   (completed_n),
    .error         (error),
    .seg_count     (seg_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every launch must be single-cycle and match the queue head.
  always @(negedge clk) begin
    seg_t e;
    if (mux_sel) mux_seen = 1'b1;
    if (rd_start_flag) begin
      flag_cnt++;
      last_flag_cyc = cyc;
      chk("flag_one_cycle", 32'(prev_flag), 32'd0);
      chk("flag_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("seg_start", rd_start_addr, e.start_addr);
        chk("seg_end", rd_end_addr, e.end_addr);
        chk("seg_switch_die", 32'(rd_switch_die), 32'(e.switch_die));
      end
    end
    prev_flag = rd_start_flag;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [31:0] s, input logic [31:0] e, output int sc);
    step();
    img_s = s; img_e = e; start = 1'b1; sc = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_flags(input int target, input int budget);
    int n = 0;
    while (flag_cnt < target && n < budget) begin
      @(negedge clk); #1; n++;
    end
    chk("flag_wait", 32'(flag_cnt >= target), 32'd1);
  endtask

  task automatic finish_seg(output int f);
    step();
    rd_finish = 1'b1; f = cyc;
    step();
    rd_finish = 1'b0;
  endtask

  task automatic wait_release(input int budget);
    int n = 0;
    while (busy_n !== 1'b1 && n < budget) begin
      @(negedge clk); #1; n++;
    end
    chk("release_wait", 32'(busy_n), 32'd1);
  endtask

  initial begin
    int s, f, e_cyc;
    repeat (3) step();
    // Reset state
    chk("rst_mux_sel", 32'(mux_sel), 32'd0);
    chk("rst_oe_ctl", 32'(oe_ctl), 32'd0);
    chk("rst_busy_n", 32'(busy_n), 32'd1);
    chk("rst_completed_n", 32'(completed_n), 32'd1);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_flag", 32'(rd_start_flag), 32'd0);
    chk("rst_switch", 32'(rd_switch_die), 32'd0);
    chk("rst_start_addr", rd_start_addr, 32'd0);
    chk("rst_end_addr", rd_end_addr, 32'd0);
    chk("rst_seg_count", 32'(seg_count), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();

    // Three full chunks in die 0; a stray rd_finish during ACQUIRE is ignored
    exp_q.push_back('{32'h0000_0000, 32'h0000_FFFF, 1'b0});
    exp_q.push_back('{32'h0001_0000, 32'h0001_FFFF, 1'b0});
    exp_q.push_back('{32'h0002_0000, 32'h0002_FFFF, 1'b0});
    go(32'h0, 32'h0002_FFFF, s);
    repeat (3) step();
    rd_finish = 1'b1; step(); rd_finish = 1'b0;
    nf++; wait_flags(nf, 100);
    chk("start_latency", 32'(last_flag_cyc - s), 32'(SETTLE + 2));
    chk("acq_mux_sel", 32'(mux_sel), 32'd1);
    chk("acq_oe_ctl", 32'(oe_ctl), 32'd1);
    chk("acq_busy_n", 32'(busy_n), 32'd0);
    chk("stray_finish_ignored", 32'(seg_count), 32'd0);
    finish_seg(f);
    nf++; wait_flags(nf, 50);
    // WAIT sees rd_finish in cycle f, NEXT at f+1, ISSUE at f+2, flag at f+3
    chk("next_latency", 32'(last_flag_cyc - f), 32'd3);
    chk("seg_count_1", 32'(seg_count), 32'd1);
    finish_seg(f);
    nf++; wait_flags(nf, 50);
    finish_seg(f);
    wait_release(100);
    chk("t1_seg_count", 32'(seg_count), 32'd3);
    chk("t1_completed_n", 32'(completed_n), 32'd0);
    chk("t1_error", 32'(error), 32'd0);
    chk("t1_mux_sel", 32'(mux_sel), 32'd0);
    chk("t1_oe_ctl", 32'(oe_ctl), 32'd0);

    // Image straddling the die boundary; a start while busy is ignored
    exp_q.push_back('{32'h01FF_8000, 32'h01FF_FFFF, 1'b0});
    exp_q.push_back('{32'h0200_0000, 32'h0200_7FFF, 1'b1});
    go(32'h01FF_8000, 32'h0200_7FFF, s);
    nf++; wait_flags(nf, 100);
    chk("t2_completed_cleared", 32'(completed_n), 32'd1);
    finish_seg(f);
    nf++; wait_flags(nf, 50);
    go(32'h0000_5000, 32'h0000_6000, s);
    finish_seg(f);
    wait_release(100);
    chk("t2_seg_count", 32'(seg_count), 32'd2);
    chk("t2_completed_n", 32'(completed_n), 32'd0);

    // FIFO backpressure holds the next launch until fifo_empty
    exp_q.push_back('{32'h0000_0000, 32'h0000_FFFF, 1'b0});
    exp_q.push_back('{32'h0001_0000, 32'h0001_FFFF, 1'b0});
    go(32'h0, 32'h0001_FFFF, s);
    nf++; wait_flags(nf, 100);
    step();
    fifo_full = 1'b1; fifo_empty = 1'b0; rd_finish = 1'b1;
    step();
    fifo_full = 1'b0; rd_finish = 1'b0;
    repeat (10) step();
    chk("pause_hold", 32'(flag_cnt), 32'(nf));
    chk("pause_seg_count", 32'(seg_count), 32'd1);
    step();
    fifo_empty = 1'b1; e_cyc = cyc;
    nf++; wait_flags(nf, 50);
    // PAUSE sees fifo_empty in e, NEXT at e+1, ISSUE at e+2, flag at e+3
    chk("pause_resume_latency", 32'(last_flag_cyc - e_cyc), 32'd3);
    finish_seg(f);
    wait_release(100);
    chk("t3_seg_count", 32'(seg_count), 32'd2);
    chk("t3_completed_n", 32'(completed_n), 32'd0);

    // Reader never finishes: timeout ends in ERR with the bus freed
    exp_q.push_back('{32'h0000_0000, 32'h0000_00FF, 1'b0});
    go(32'h0, 32'h0000_00FF, s);
    nf++; wait_flags(nf, 100);
    wait_release(TMO + 100);
    chk("tmo_error", 32'(error), 32'd1);
    chk("tmo_mux_sel", 32'(mux_sel), 32'd0);
    chk("tmo_busy_n", 32'(busy_n), 32'd1);
    chk("tmo_completed_n", 32'(completed_n), 32'd1);
    chk("tmo_seg_count", 32'(seg_count), 32'd0);

    // Abort during segment 2 (abort beats a coincident rd_finish)
    exp_q.push_back('{32'h0000_0000, 32'h0000_FFFF, 1'b0});
    exp_q.push_back('{32'h0001_0000, 32'h0001_FFFF, 1'b0});
    go(32'h0, 32'h0002_FFFF, s);
    nf++; wait_flags(nf, 100);
    chk("err_cleared_on_start", 32'(error), 32'd0);
    finish_seg(f);
    nf++; wait_flags(nf, 50);
    step(); step();
    abort = 1'b1; rd_finish = 1'b1;
    step();
    abort = 1'b0; rd_finish = 1'b0;
    wait_release(100);
    chk("abort_completed_n", 32'(completed_n), 32'd1);
    chk("abort_error", 32'(error), 32'd0);
    chk("abort_seg_count", 32'(seg_count), 32'd1);
    chk("abort_mux_sel", 32'(mux_sel), 32'd0);
    repeat (20) step();
    chk("abort_no_more_flags", 32'(flag_cnt), 32'(nf));

    // Top-of-space image: single segment ending at 32'hFFFF_FFFF, die 0x7F
    exp_q.push_back('{32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1});
    go(32'hFFFF_FFF0, 32'hFFFF_FFFF, s);
    nf++; wait_flags(nf, 100);
    finish_seg(f);
    wait_release(100);
    chk("top_seg_count", 32'(seg_count), 32'd1);
    chk("top_completed_n", 32'(completed_n), 32'd0);
    repeat (20) step();
    chk("top_no_wrap_flag", 32'(flag_cnt), 32'(nf));

    // Inverted range goes straight to ERR without touching the bus
    mux_seen = 1'b0;
    go(32'h0000_0100, 32'h0000_0050, s);
    repeat (30) step();
    chk("inv_error", 32'(error), 32'd1);
    chk("inv_mux_never", 32'(mux_seen), 32'd0);
    chk("inv_busy_n", 32'(busy_n), 32'd1);
    chk("inv_completed_n", 32'(completed_n), 32'd1);

    // Reset mid-copy frees the bus at once and stops further launches
    exp_q.push_back('{32'h0000_0000, 32'h0000_FFFF, 1'b0});
    go(32'h0, 32'h0002_FFFF, s);
    nf++; wait_flags(nf, 100);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mux_sel", 32'(mux_sel), 32'd0);
    chk("rst_mid_oe_ctl", 32'(oe_ctl), 32'd0);
    chk("rst_mid_busy_n", 32'(busy_n), 32'd1);
    step();
    rst_n = 1'b1;
    repeat (40) step();
    chk("rst_mid_no_flag", 32'(flag_cnt), 32'(nf));
    chk("rst_mid_seg_count", 32'(seg_count), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
